regfile_param: RTL and testbench

Parametrised multi-read-port register file with same-cycle write bypass, an optional hardwired zero register, and a per-register busy scoreboard for in-flight results. It sits in the CPU decode stage and is the next generation of the fixed 16x16, two-read-port register file. Decode reads operands and their busy flags in one cycle. Issue marks a destination busy. Writeback writes the data and clears the busy flag.

---
 rtl/regfile_param.sv | 99 +++++++++
 tb/tb_regfile_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file for the decode stage.
// Provides NREAD combinational read ports with same-cycle writeback bypass,
// an optional hardwired zero register, and a per-register busy scoreboard.
// Issue sets a register busy on the next edge. Writeback clears it on the
// next edge and already reads as not-busy in the writeback cycle.
// DEPTH must be a power of two (>= 2) and NREAD must be in 1..4.
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WriteReg,
  input  logic [ADDR_W-1:0]       DstReg,
  input  logic [WIDTH-1:0]        DstData,
  input  logic                    IssueValid,
  input  logic [ADDR_W-1:0]       IssueReg,
  input  logic [NREAD*ADDR_W-1:0] SrcReg,
  output logic [NREAD*WIDTH-1:0]  SrcData,
  output logic [NREAD-1:0]        SrcBusy
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_en;

  // Writes aimed at the hardwired zero register are dropped here, so the
  // array entry for r0 stays at its reset value of zero.
  assign wr_en = WriteReg && !(HAS_ZERO && (DstReg == '0));

  // Next busy vector: issue sets, writeback clears, issue wins a tie because
  // the newly issued producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (IssueValid && (IssueReg == ADDR_W'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (WriteReg && (DstReg == ADDR_W'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    if (HAS_ZERO) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Storage update: reset clears data and abandons every pending producer;
  // anything presented during the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_en) begin
        mem[DstReg] <= DstData;
      end
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic              hit;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_busy;

    assign sel = SrcReg[i*ADDR_W +: ADDR_W];
    assign hit = WriteReg && (DstReg == sel);

    // Read mux: reset and zero register force zero, else a same-cycle
    // writeback bypasses the array and also masks the busy flag.
    always_comb begin
      rd_data = mem[sel];
      rd_busy = busy[sel];
      if (rst) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end else if (HAS_ZERO && (sel == '0)) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end else if (hit) begin
        rd_data = DstData;
        rd_busy = 1'b0;
      end
    end

    assign SrcData[i*WIDTH +: WIDTH] = rd_data;
    assign SrcBusy[i]                = rd_busy;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param.
// Two 16x16 instances (without / with zero register) share one stimulus
// stream; a 32x32 four-port instance has its own. Stimulus pushes expected
// port values into a queue; a monitor on the falling edge pops and compares.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared narrow stimulus
  logic        wr = 1'b0;
  logic [3:0]  dst = '0;
  logic [15:0] dd = '0;
  logic        iv = 1'b0;
  logic [3:0]  ir = '0;
  logic [7:0]  src = '0;
  logic [31:0] sd_a, sd_z;
  logic [1:0]  sb_a, sb_z;

  // wide stimulus
  logic         wr_w = 1'b0;
  logic [4:0]   dst_w = '0;
  logic [31:0]  dd_w = '0;
  logic         iv_w = 1'b0;
  logic [4:0]   ir_w = '0;
  logic [19:0]  src_w = '0;
  logic [127:0] sd_w;
  logic [3:0]   sb_w;

  regfile_param #(.WIDTH(16), .DEPTH(16), .NREAD(2), .ZERO_REG(0)) u_a (
    .clk(clk), .rst(rst), .WriteReg(wr), .DstReg(dst), .DstData(dd),
    .IssueValid(iv), .IssueReg(ir), .SrcReg(src), .SrcData(sd_a), .SrcBusy(sb_a)
  );

  regfile_param #(.WIDTH(16), .DEPTH(16), .NREAD(2), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .WriteReg(wr), .DstReg(dst), .DstData(dd),
    .IssueValid(iv), .IssueReg(ir), .SrcReg(src), .SrcData(sd_z), .SrcBusy(sb_z)
  );

  regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(4), .ZERO_REG(1)) u_w (
    .clk(clk), .rst(rst), .WriteReg(wr_w), .DstReg(dst_w), .DstData(dd_w),
    .IssueValid(iv_w), .IssueReg(ir_w), .SrcReg(src_w), .SrcData(sd_w), .SrcBusy(sb_w)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act_data(input int dut, input int port);
    case (dut)
      0:       return {16'h0, sd_a[port*16 +: 16]};
      1:       return {16'h0, sd_z[port*16 +: 16]};
      default: return sd_w[port*32 +: 32];
    endcase
  endfunction

  function automatic logic act_busy(input int dut, input int port);
    case (dut)
      0:       return sb_a[port];
      1:       return sb_z[port];
      default: return sb_w[port];
    endcase
  endfunction

  // monitor: compare every expectation registered for the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      logic [31:0] ad;
      logic        ab;
      e = q.pop_front();
      ad = act_data(e.dut, e.port);
      ab = act_busy(e.dut, e.port);
      checks++;
      if (ad !== e.data || ab !== e.busy) begin
        errors++;
        $display("FAIL %s dut%0d port%0d cyc%0d: got data=%h busy=%b, want data=%h busy=%b",
                 e.name, e.dut, e.port, cyc, ad, ab, e.data, e.busy);
      end
    end
  end

  task automatic ex(input int dut, input int port, input logic [31:0] d,
                    input logic b, input string nm);
    exp_t x;
    x.cyc = cyc; x.dut = dut; x.port = port; x.data = d; x.busy = b; x.name = nm;
    q.push_back(x);
  endtask

  // same port expectation on the plain (a) and zero-register (z) instances
  task automatic ex2(input int port, input logic [15:0] da, input logic ba,
                     input logic [15:0] dz, input logic bz, input string nm);
    ex(0, port, {16'h0, da}, ba, nm);
    ex(1, port, {16'h0, dz}, bz, nm);
  endtask

  task automatic drv(input logic w, input logic [3:0] d, input logic [15:0] v,
                     input logic i, input logic [3:0] r,
                     input logic [3:0] s0, input logic [3:0] s1);
    @(posedge clk); #1;
    wr = w; dst = d; dd = v; iv = i; ir = r; src = {s1, s0};
  endtask

  task automatic drvw(input logic w, input logic [4:0] d, input logic [31:0] v,
                      input logic i, input logic [4:0] r,
                      input logic [4:0] s0, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] s3);
    @(posedge clk); #1;
    wr_w = w; dst_w = d; dd_w = v; iv_w = i; ir_w = r; src_w = {s3, s2, s1, s0};
  endtask

  initial begin
    logic [15:0] v;

    // reset: outputs forced to zero, write/issue in the reset cycle lost
    drv(1, 3, 16'h1111, 1, 4, 3, 4);
    ex2(0, 16'h0, 0, 16'h0, 0, "rst_out");
    ex2(1, 16'h0, 0, 16'h0, 0, "rst_out");
    drv(0, 0, 0, 0, 0, 3, 4);
    rst = 1'b0;
    ex2(0, 16'h0, 0, 16'h0, 0, "post_rst_r3");
    ex2(1, 16'h0, 0, 16'h0, 0, "post_rst_r4");
    ex(2, 0, 32'h0, 0, "post_rst_wide");

    // sweep: bypass in write cycle, array on the next
    for (int r = 0; r < 16; r++) begin
      v = (r % 2 == 0) ? 16'hDEAD : 16'hBEEF;
      drv(1, 4'(r), v, 0, 0, 4'(r), 4'(r));
      for (int p = 0; p < 2; p++) ex2(p, v, 0, (r == 0) ? 16'h0 : v, 0, "sweep_byp");
      drv(0, 0, 0, 0, 0, 4'(r), 4'(r));
      for (int p = 0; p < 2; p++) ex2(p, v, 0, (r == 0) ? 16'h0 : v, 0, "sweep_arr");
    end

    // zero register
    drv(1, 0, 16'h1234, 0, 0, 0, 0);
    ex2(0, 16'h1234, 0, 16'h0, 0, "zero_wr");
    ex2(1, 16'h1234, 0, 16'h0, 0, "zero_wr");
    drv(0, 0, 0, 1, 0, 0, 1);
    ex2(0, 16'h1234, 0, 16'h0, 0, "zero_iss");
    ex2(1, 16'hBEEF, 0, 16'hBEEF, 0, "zero_iss_r1");
    drv(0, 0, 0, 0, 0, 0, 1);
    ex2(0, 16'h1234, 1, 16'h0, 0, "zero_busy");
    ex2(1, 16'hBEEF, 0, 16'hBEEF, 0, "zero_busy_r1");
    drv(1, 1, 16'h1234, 0, 0, 1, 0);
    ex2(0, 16'h1234, 0, 16'h1234, 0, "r1_byp");
    ex2(1, 16'h1234, 1, 16'h0, 0, "r1_byp_r0");
    drv(0, 0, 0, 0, 0, 1, 1);
    ex2(0, 16'h1234, 0, 16'h1234, 0, "r1_arr");
    ex2(1, 16'h1234, 0, 16'h1234, 0, "r1_arr");
    drv(1, 0, 16'h0BAD, 0, 0, 0, 0);
    ex2(0, 16'h0BAD, 0, 16'h0, 0, "r0_clr_byp");
    drv(0, 0, 0, 0, 0, 0, 0);
    ex2(0, 16'h0BAD, 0, 16'h0, 0, "r0_clr_arr");

    // scoreboard on r5
    drv(0, 0, 0, 1, 5, 5, 5);
    ex2(0, 16'hBEEF, 0, 16'hBEEF, 0, "r5_t");
    ex2(1, 16'hBEEF, 0, 16'hBEEF, 0, "r5_t");
    drv(0, 0, 0, 0, 0, 5, 5);
    ex2(0, 16'hBEEF, 1, 16'hBEEF, 1, "r5_t1");
    ex2(1, 16'hBEEF, 1, 16'hBEEF, 1, "r5_t1");
    drv(0, 0, 0, 0, 0, 5, 5);
    ex2(0, 16'hBEEF, 1, 16'hBEEF, 1, "r5_t2");
    drv(1, 5, 16'hCAFE, 0, 0, 5, 5);
    ex2(0, 16'hCAFE, 0, 16'hCAFE, 0, "r5_t3");
    ex2(1, 16'hCAFE, 0, 16'hCAFE, 0, "r5_t3");
    drv(0, 0, 0, 0, 0, 5, 5);
    ex2(0, 16'hCAFE, 0, 16'hCAFE, 0, "r5_t4");
    ex2(1, 16'hCAFE, 0, 16'hCAFE, 0, "r5_t4");

    // simultaneous issue and writeback on r7
    drv(1, 7, 16'h7777, 0, 0, 7, 7);
    ex2(0, 16'h7777, 0, 16'h7777, 0, "r7_pre");
    drv(0, 0, 0, 1, 7, 7, 7);
    ex2(0, 16'h7777, 0, 16'h7777, 0, "r7_iss");
    drv(1, 7, 16'hBEEF, 1, 7, 7, 7);
    ex2(0, 16'hBEEF, 0, 16'hBEEF, 0, "r7_both");
    drv(0, 0, 0, 0, 0, 7, 7);
    ex2(0, 16'hBEEF, 1, 16'hBEEF, 1, "r7_after");
    ex2(1, 16'hBEEF, 1, 16'hBEEF, 1, "r7_after");
    drv(1, 7, 16'h0001, 0, 0, 7, 7);
    ex2(0, 16'h0001, 0, 16'h0001, 0, "r7_wb");
    drv(0, 0, 0, 0, 0, 7, 7);
    ex2(0, 16'h0001, 0, 16'h0001, 0, "r7_done");

    // mid-operation reset
    drv(1, 2, 16'h00FF, 0, 0, 2, 2);
    ex2(0, 16'h00FF, 0, 16'h00FF, 0, "r2_wr");
    drv(0, 0, 0, 1, 2, 2, 2);
    ex2(0, 16'h00FF, 0, 16'h00FF, 0, "r2_iss");
    drv(0, 0, 0, 0, 0, 2, 2);
    ex2(0, 16'h00FF, 1, 16'h00FF, 1, "r2_busy");
    drv(1, 2, 16'h5555, 1, 2, 2, 5);
    rst = 1'b1;
    ex2(0, 16'h0, 0, 16'h0, 0, "mid_rst");
    ex2(1, 16'h0, 0, 16'h0, 0, "mid_rst");
    drv(0, 0, 0, 0, 0, 2, 5);
    rst = 1'b0;
    ex2(0, 16'h0, 0, 16'h0, 0, "mid_rst_r2");
    ex2(1, 16'h0, 0, 16'h0, 0, "mid_rst_r5");
    drv(0, 0, 0, 0, 0, 2, 5);
    ex2(0, 16'h0, 0, 16'h0, 0, "mid_rst_r2_later");

    // wide, four ports
    drvw(1, 3, 32'h13579BDF, 0, 0, 3, 3, 3, 3);
    for (int p = 0; p < 4; p++) ex(2, p, 32'h13579BDF, 0, "w_r3_byp");
    drvw(0, 0, 0, 1, 3, 3, 3, 3, 3);
    for (int p = 0; p < 4; p++) ex(2, p, 32'h13579BDF, 0, "w_r3_iss");
    drvw(1, 31, 32'hA5A5A5A5, 0, 0, 3, 3, 31, 0);
    ex(2, 0, 32'h13579BDF, 1, "w_p0");
    ex(2, 1, 32'h13579BDF, 1, "w_p1");
    ex(2, 2, 32'hA5A5A5A5, 0, "w_p2_byp");
    ex(2, 3, 32'h0, 0, "w_p3_zero");
    drvw(1, 0, 32'hFFFFFFFF, 1, 0, 3, 3, 31, 0);
    ex(2, 2, 32'hA5A5A5A5, 0, "w_p2_arr");
    ex(2, 3, 32'h0, 0, "w_r0_wr");
    drvw(0, 0, 0, 0, 0, 3, 3, 31, 0);
    ex(2, 0, 32'h13579BDF, 1, "w_p0_late");
    ex(2, 3, 32'h0, 0, "w_r0_after");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
